store_buffer: RTL and testbench



---
 rtl/store_buffer_if.sv | 61 ++++++
 rtl/store_buffer.sv | 183 ++++++++++++++++++
 tb/tb_store_buffer.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/store_buffer_if.sv
`default_nettype none
// ============================================================================
//  Module      : store_buffer_if
//  Description : Pipeline-side store/load/fence signals and the memory write
//                port of the store buffer, bundled with master (pipeline)
//                and slave (buffer) views.
//                STORE_BUF_FWD_EN adds the load-forwarding signals.
//  Revision    : 1.0 - initial release
// ============================================================================
interface store_buffer_if #(
   parameter int WIDTH = 32
);
   logic             store_valid_i;
   logic             store_ready_o;
   logic [WIDTH-1:0] store_a_i;
   logic [WIDTH-1:0] store_wd_i;
   logic [1:0]       store_memtype_i;
   logic             load_valid_i;
   logic [WIDTH-1:0] load_a_i;
   logic [1:0]       load_memtype_i;
   logic             load_memsign_i;
   logic             load_stall_o;
   logic             fence_i;
   logic             busy_o;
   logic             mem_write_en_o;
   logic [WIDTH-1:0] mem_a_o;
   logic [WIDTH-1:0] mem_wd_o;
   logic [1:0]       mem_memtype_o;
   logic             mem_memsign_o;
`ifdef STORE_BUF_FWD_EN
   logic             load_fwd_valid_o;
   logic [WIDTH-1:0] load_fwd_data_o;
`endif

   // Buffer view
   modport slave (
      input  store_valid_i, store_a_i, store_wd_i, store_memtype_i,
      input  load_valid_i, load_a_i, load_memtype_i, load_memsign_i,
      input  fence_i,
      output store_ready_o, load_stall_o, busy_o,
      output mem_write_en_o, mem_a_o, mem_wd_o, mem_memtype_o, mem_memsign_o
`ifdef STORE_BUF_FWD_EN
      ,
      output load_fwd_valid_o, load_fwd_data_o
`endif
   );

   // Pipeline / memory view
   modport master (
      output store_valid_i, store_a_i, store_wd_i, store_memtype_i,
      output load_valid_i, load_a_i, load_memtype_i, load_memsign_i,
      output fence_i,
      input  store_ready_o, load_stall_o, busy_o,
      input  mem_write_en_o, mem_a_o, mem_wd_o, mem_memtype_o, mem_memsign_o
`ifdef STORE_BUF_FWD_EN
      ,
      input  load_fwd_valid_o, load_fwd_data_o
`endif
   );
endinterface
`default_nettype wire

// File: rtl/store_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : store_buffer
//  Description : Posted-write FIFO between the memory pipeline stage and the
//                data memory. Stores drain one per cycle whenever no load owns
//                the memory port; loads stall on a word-address hazard with a
//                pending store or while a fence drains the queue.
//                Optional macro STORE_BUF_FWD_EN: forward whole-word store
//                data to a matching whole-word load instead of stalling.
//  Revision    : 1.0 - initial release
// ============================================================================
module store_buffer #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  wire logic     clk_i,
   input  wire logic     rst_n_i,
   store_buffer_if.slave bus
);
   localparam int               PTR_W      = $clog2(DEPTH);
   localparam int               CNT_W      = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
   localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);
   localparam logic [0:0]       ST_RUN     = 1'b0;
   localparam logic [0:0]       ST_FENCE   = 1'b1;

   logic [WIDTH-1:0] ent_a_q  [DEPTH];
   logic [WIDTH-1:0] ent_wd_q [DEPTH];
   logic [1:0]       ent_mt_q [DEPTH];

   logic [PTR_W-1:0] head_q, head_d;
   logic [PTR_W-1:0] tail_q, tail_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [0:0]       state_q, state_d;

   logic             in_fence;
   logic             store_ready;
   logic             busy;
   logic             enq;
   logic             hit;
   logic             fwd_ok;
   logic             load_stall;
   logic             load_take;
   logic             drain;
   logic [PTR_W-1:0] idx;
`ifdef STORE_BUF_FWD_EN
   logic [PTR_W-1:0] young;
`endif

   logic             mem_we;
   logic [WIDTH-1:0] mem_a;
   logic [WIDTH-1:0] mem_wd;
   logic [1:0]       mem_mt;
   logic             mem_sg;

   // Entry storage: written at the tail on enqueue; contents need no reset
   always_ff @(posedge clk_i) begin
      if (enq) begin
         ent_a_q[tail_q]  <= bus.store_a_i;
         ent_wd_q[tail_q] <= bus.store_wd_i;
         ent_mt_q[tail_q] <= bus.store_memtype_i;
      end
   end

   // Word-address hazard scan over pending entries, oldest to youngest
   always_comb begin
      hit = 1'b0;
      idx = '0;
`ifdef STORE_BUF_FWD_EN
      young = '0;
`endif
      for (int k = 0; k < DEPTH; k++) begin
         idx = head_q + PTR_W'(k);
         if ((CNT_W'(k) < count_q) &&
             (ent_a_q[idx][WIDTH-1:2] == bus.load_a_i[WIDTH-1:2])) begin
            hit = 1'b1;
`ifdef STORE_BUF_FWD_EN
            young = idx;
`endif
         end
      end
   end

   // Forward decision, stall and port arbitration between load and drain
   always_comb begin
`ifdef STORE_BUF_FWD_EN
      // The youngest match holds the newest data for that word
      fwd_ok = hit && (ent_a_q[young] == bus.load_a_i) &&
               (ent_mt_q[young] == 2'b00) && (bus.load_memtype_i == 2'b00);
`else
      fwd_ok = 1'b0;
`endif
      load_stall = bus.load_valid_i && (in_fence || (hit && !fwd_ok));
      load_take  = bus.load_valid_i && !load_stall;
      drain      = !load_take && (count_q != '0);
      enq        = bus.store_valid_i && store_ready;
   end

   // Memory port mux
   always_comb begin
      mem_we = 1'b0;
      mem_a  = '0;
      mem_wd = '0;
      mem_mt = 2'b00;
      mem_sg = 1'b0;
      if (load_take) begin
         mem_a  = bus.load_a_i;
         mem_mt = bus.load_memtype_i;
         mem_sg = bus.load_memsign_i;
      end else if (drain) begin
         mem_we = 1'b1;
         mem_a  = ent_a_q[head_q];
         mem_wd = ent_wd_q[head_q];
         mem_mt = ent_mt_q[head_q];
      end
   end

   // Pointer and occupancy next state; enqueue plus drain leaves count as is
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (enq)   tail_d = tail_q + PTR_ONE;
      if (drain) head_d = head_q + PTR_ONE;
      case ({enq, drain})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase
   end

   // Pointer and occupancy registers; reset discards everything pending
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // FSM state register
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) state_q <= ST_RUN;
      else          state_q <= state_d;
   end

   // FSM next state: fence always enters FENCE, leaves once the queue is empty
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_RUN:   if (bus.fence_i)      state_d = ST_FENCE;
         ST_FENCE: if (count_q == '0)    state_d = ST_RUN;
         default:                        state_d = ST_RUN;
      endcase
   end

   // FSM outputs: store acceptance never looks at the same-cycle drain
   always_comb begin
      in_fence    = (state_q == ST_FENCE);
      store_ready = (count_q != FULL_COUNT) && !in_fence;
      busy        = (count_q != '0) || in_fence;
   end

   assign bus.store_ready_o  = store_ready;
   assign bus.load_stall_o   = load_stall;
   assign bus.busy_o         = busy;
   assign bus.mem_write_en_o = mem_we;
   assign bus.mem_a_o        = mem_a;
   assign bus.mem_wd_o       = mem_wd;
   assign bus.mem_memtype_o  = mem_mt;
   assign bus.mem_memsign_o  = mem_sg;
`ifdef STORE_BUF_FWD_EN
   assign bus.load_fwd_valid_o = bus.load_valid_i && !in_fence && fwd_ok;
   assign bus.load_fwd_data_o  = (bus.load_valid_i && !in_fence && fwd_ok) ?
                                 ent_wd_q[young] : '0;
`endif
endmodule
`default_nettype wire

// File: tb/tb_store_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_store_buffer
//  Description : Directed bench for store_buffer. Stimulus pushes every
//                expected memory write into a queue; a monitor pops and
//                compares on each write it sees. Port, stall and status
//                outputs are checked inline against hand-computed values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_store_buffer;
   typedef struct {
      logic [31:0] a;
      logic [31:0] wd;
      logic [1:0]  mt;
   } wr_t;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_fail;
   wr_t  exp_q[$];

   store_buffer_if #(.WIDTH(32)) bus ();

   store_buffer #(.WIDTH(32), .DEPTH(4)) dut (
      .clk_i   (clk),
      .rst_n_i (rst_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_store(input logic v, input logic [31:0] a, input logic [31:0] wd, input logic [1:0] mt);
      bus.store_valid_i   = v;
      bus.store_a_i       = a;
      bus.store_wd_i      = wd;
      bus.store_memtype_i = mt;
   endtask

   task automatic set_load(input logic v, input logic [31:0] a, input logic [1:0] mt, input logic sg);
      bus.load_valid_i   = v;
      bus.load_a_i       = a;
      bus.load_memtype_i = mt;
      bus.load_memsign_i = sg;
   endtask

   task automatic push(input logic [31:0] a, input logic [31:0] wd, input logic [1:0] mt);
      wr_t e;
      e.a  = a;
      e.wd = wd;
      e.mt = mt;
      exp_q.push_back(e);
   endtask

   // Write monitor: every memory write must match the oldest expected store
   always @(negedge clk) begin
      if (!rst_n) begin
         check("no_write_in_reset", {31'd0, bus.mem_write_en_o}, 32'd0);
      end else if (bus.mem_write_en_o) begin
         if (exp_q.size() == 0) begin
            check("unexpected_write_addr", bus.mem_a_o, 32'hFFFF_FFFF);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            check("wr_addr",    bus.mem_a_o,                 e.a);
            check("wr_data",    bus.mem_wd_o,                e.wd);
            check("wr_memtype", {30'd0, bus.mem_memtype_o},  {30'd0, e.mt});
            check("wr_memsign", {31'd0, bus.mem_memsign_o},  32'd0);
         end
      end
   end

   // Watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time %0t exceeded, expected finish earlier", $time);
      $fatal(1);
   end

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst_n    = 1'b0;
      bus.fence_i = 1'b0;
      set_store(1'b0, 32'd0, 32'd0, 2'b00);
      set_load(1'b0, 32'd0, 2'b00, 1'b0);
      #2;
      check("rst_ready",  {31'd0, bus.store_ready_o},  32'd1);
      check("rst_busy",   {31'd0, bus.busy_o},         32'd0);
      check("rst_stall",  {31'd0, bus.load_stall_o},   32'd0);
      check("rst_we",     {31'd0, bus.mem_write_en_o}, 32'd0);
      check("rst_mem_a",  bus.mem_a_o,                 32'd0);
      tick();
      tick();
      rst_n = 1'b1;

      // Fill to DEPTH while an unrelated load holds the port
      for (int i = 0; i < 4; i++) begin
         tick();
         set_store(1'b1, 32'h100 + 32'(4 * i), 32'hA0 + 32'(i), 2'b00);
         set_load(1'b1, 32'h800, 2'b00, 1'b0);
         #1;
         check("fill_ready", {31'd0, bus.store_ready_o},  32'd1);
         check("fill_stall", {31'd0, bus.load_stall_o},   32'd0);
         check("fill_port",  bus.mem_a_o,                 32'h800);
         check("fill_no_we", {31'd0, bus.mem_write_en_o}, 32'd0);
         push(32'h100 + 32'(4 * i), 32'hA0 + 32'(i), 2'b00);
      end
      // Full: store held while the head drains, accepted one cycle later
      tick();
      set_store(1'b1, 32'h110, 32'hA4, 2'b00);
      set_load(1'b0, 32'd0, 2'b00, 1'b0);
      #1;
      check("full_ready", {31'd0, bus.store_ready_o}, 32'd0);
      check("full_busy",  {31'd0, bus.busy_o},        32'd1);
      tick();
      check("retry_ready", {31'd0, bus.store_ready_o}, 32'd1);
      push(32'h110, 32'hA4, 2'b00);
      tick();
      set_store(1'b0, 32'd0, 32'd0, 2'b00);
      repeat (3) tick();
      check("drained_busy", {31'd0, bus.busy_o}, 32'd0);

      // Hazard: byte store 0x201 against word load 0x200
      tick();
      set_store(1'b1, 32'h201, 32'h55, 2'b10);
      set_load(1'b1, 32'h300, 2'b00, 1'b0);
      #1;
      check("hz_par_stall", {31'd0, bus.load_stall_o}, 32'd0);
      check("hz_par_port",  bus.mem_a_o,               32'h300);
      push(32'h201, 32'h55, 2'b10);
      tick();
      set_store(1'b0, 32'd0, 32'd0, 2'b00);
      #1;
      check("hz_block_stall", {31'd0, bus.load_stall_o},   32'd0);
      check("hz_block_we",    {31'd0, bus.mem_write_en_o}, 32'd0);
      check("hz_block_port",  bus.mem_a_o,                 32'h300);
      tick();
      set_load(1'b1, 32'h200, 2'b00, 1'b1);
      #1;
      check("hz_stall",    {31'd0, bus.load_stall_o},   32'd1);
      check("hz_drain_we", {31'd0, bus.mem_write_en_o}, 32'd1);
      tick();
      check("hz_clear_stall", {31'd0, bus.load_stall_o},   32'd0);
      check("hz_load_we",     {31'd0, bus.mem_write_en_o}, 32'd0);
      check("hz_load_a",      bus.mem_a_o,                 32'h200);
      check("hz_load_sign",   {31'd0, bus.mem_memsign_o},  32'd1);
      tick();
      set_load(1'b0, 32'd0, 2'b00, 1'b0);

      // Fence with 3 entries pending
      for (int i = 0; i < 3; i++) begin
         tick();
         set_store(1'b1, 32'h500 + 32'(4 * i), 32'hD0 + 32'(i), 2'b00);
         set_load(1'b1, 32'h800, 2'b00, 1'b0);
         push(32'h500 + 32'(4 * i), 32'hD0 + 32'(i), 2'b00);
      end
      tick();
      set_store(1'b0, 32'd0, 32'd0, 2'b00);
      set_load(1'b0, 32'd0, 2'b00, 1'b0);
      bus.fence_i = 1'b1;
      #1;
      check("fence_req_ready", {31'd0, bus.store_ready_o}, 32'd1);
      tick();
      bus.fence_i = 1'b0;
      set_store(1'b1, 32'h600, 32'hE0, 2'b00);
      set_load(1'b1, 32'h900, 2'b00, 1'b0);
      for (int j = 0; j < 3; j++) begin
         #1;
         check("fence_ready", {31'd0, bus.store_ready_o}, 32'd0);
         check("fence_stall", {31'd0, bus.load_stall_o},  32'd1);
         check("fence_busy",  {31'd0, bus.busy_o},        32'd1);
         if (j < 2) tick();
      end
      tick();
      check("fence_done_ready", {31'd0, bus.store_ready_o}, 32'd1);
      check("fence_done_busy",  {31'd0, bus.busy_o},        32'd0);
      check("fence_done_stall", {31'd0, bus.load_stall_o},  32'd0);
      push(32'h600, 32'hE0, 2'b00);
      tick();
      set_store(1'b0, 32'd0, 32'd0, 2'b00);
      set_load(1'b0, 32'd0, 2'b00, 1'b0);
      tick();
      check("post_fence_busy", {31'd0, bus.busy_o}, 32'd0);

      // Fence when empty: exactly one FENCE cycle
      tick();
      bus.fence_i = 1'b1;
      #1;
      check("efence_req_ready", {31'd0, bus.store_ready_o}, 32'd1);
      tick();
      bus.fence_i = 1'b0;
      check("efence_ready", {31'd0, bus.store_ready_o}, 32'd0);
      check("efence_busy",  {31'd0, bus.busy_o},        32'd1);
      tick();
      check("efence_back_ready", {31'd0, bus.store_ready_o}, 32'd1);
      check("efence_back_busy",  {31'd0, bus.busy_o},        32'd0);

      // Reset with 2 entries pending
      for (int i = 0; i < 2; i++) begin
         tick();
         set_store(1'b1, 32'h700 + 32'(4 * i), 32'hE1 + 32'(i), 2'b00);
         set_load(1'b1, 32'h800, 2'b00, 1'b0);
         push(32'h700 + 32'(4 * i), 32'hE1 + 32'(i), 2'b00);
      end
      tick();
      set_store(1'b0, 32'd0, 32'd0, 2'b00);
      set_load(1'b0, 32'd0, 2'b00, 1'b0);
      #1;
      check("prerst_we", {31'd0, bus.mem_write_en_o}, 32'd1);
      check("prerst_a",  bus.mem_a_o,                 32'h700);
      rst_n = 1'b0;
      #1;
      check("rst_mid_we",    {31'd0, bus.mem_write_en_o}, 32'd0);
      check("rst_mid_busy",  {31'd0, bus.busy_o},         32'd0);
      check("rst_mid_ready", {31'd0, bus.store_ready_o},  32'd1);
      exp_q.delete();
      tick();
      tick();
      rst_n = 1'b1;
      #1;
      check("rst_rel_busy", {31'd0, bus.busy_o},         32'd0);
      check("rst_rel_we",   {31'd0, bus.mem_write_en_o}, 32'd0);
      repeat (5) tick();

      // Whole-word store followed by same-address loads
      tick();
      set_store(1'b1, 32'h400, 32'hDEAD_BEEF, 2'b00);
      #1;
      check("fwd_st_ready", {31'd0, bus.store_ready_o}, 32'd1);
      push(32'h400, 32'hDEAD_BEEF, 2'b00);
      tick();
      set_store(1'b0, 32'd0, 32'd0, 2'b00);
      set_load(1'b1, 32'h400, 2'b00, 1'b0);
      #1;
`ifdef STORE_BUF_FWD_EN
      check("fwd_stall", {31'd0, bus.load_stall_o},     32'd0);
      check("fwd_valid", {31'd0, bus.load_fwd_valid_o}, 32'd1);
      check("fwd_data",  bus.load_fwd_data_o,           32'hDEAD_BEEF);
      check("fwd_port",  bus.mem_a_o,                   32'h400);
      check("fwd_no_we", {31'd0, bus.mem_write_en_o},   32'd0);
      tick();
      set_load(1'b1, 32'h400, 2'b01, 1'b0);
      #1;
      check("fwd_half_stall", {31'd0, bus.load_stall_o},     32'd1);
      check("fwd_half_valid", {31'd0, bus.load_fwd_valid_o}, 32'd0);
      check("fwd_half_we",    {31'd0, bus.mem_write_en_o},   32'd1);
`else
      check("word_hz_stall", {31'd0, bus.load_stall_o},   32'd1);
      check("word_hz_we",    {31'd0, bus.mem_write_en_o}, 32'd1);
      tick();
      set_load(1'b1, 32'h400, 2'b01, 1'b0);
      #1;
      check("half_after_stall", {31'd0, bus.load_stall_o}, 32'd0);
      check("half_after_port",  bus.mem_a_o,               32'h400);
`endif
      tick();
      set_load(1'b0, 32'd0, 2'b00, 1'b0);
      repeat (2) tick();

      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
